// File: rtl/int_ctrl.sv
// int_ctrl: prioritised NUM_CH-source interrupt controller feeding the 8-bit CPU's int_req/int_vec path.
// Define INT_CTRL_NESTING_EN to let a strictly higher-priority source preempt a running handler.
module int_ctrl #(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_W     = 8,
    parameter int unsigned VEC_BASE   = 32'hE0,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic              mask_w_en,
    input  logic [NUM_CH-1:0] mask_w_data,
    input  logic              gie_w_en,
    input  logic              gie_w_data,
    input  logic              int_ack,
    input  logic              int_ret,
    output logic              int_req,
    output logic [DATA_W-1:0] int_vec,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] in_service,
    output logic [NUM_CH-1:0] mask,
    output logic              gie
);
    // state   | meaning
    // IDLE    | nothing requested; pick the best candidate
    // REQ     | int_req raised for the latched channel, awaiting ack
    // SERVICE | handler running, awaiting ret
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DATA_W-1:0] VEC_RST = DATA_W'(VEC_BASE);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] irq_prev_q, irq_prev_d;
    logic              armed_q, armed_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] in_service_q, in_service_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              gie_q, gie_d;
    logic [IDX_W-1:0]  req_ch_q, req_ch_d;
    logic [DATA_W-1:0] int_vec_q, int_vec_d;

    logic              cand_valid;
    logic [IDX_W-1:0]  cand_idx;
    logic [DATA_W-1:0] cand_vec;
    logic [NUM_CH-1:0] req_oh;
    logic [NUM_CH-1:0] is_top_oh;
    logic [NUM_CH-1:0] edge_set;
    logic              is_any;
    logic              withdraw;
    logic              latch;
    logic              ack_take;
    logic              ret_take;
`ifdef INT_CTRL_NESTING_EN
    logic [IDX_W-1:0]  is_top_idx;
    logic              preempt;
`endif

    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i] && mask_q[i]) begin
                cand_valid = gie_q;
                cand_idx   = IDX_W'(i);
            end
        end
        cand_vec  = DATA_W'(VEC_BASE + 32'(cand_idx) * VEC_STRIDE);
        req_oh    = NUM_CH'(1) << req_ch_q;
        // lowest set bit = highest-priority handler currently in service
        is_top_oh = in_service_q & (~in_service_q + NUM_CH'(1));
        is_any    = |in_service_q;
        withdraw  = !gie_q || !mask_q[req_ch_q] || !pending_q[req_ch_q];
    end

`ifdef INT_CTRL_NESTING_EN
    always_comb begin
        is_top_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_service_q[i]) is_top_idx = IDX_W'(i);
        end
        preempt = cand_valid && is_any && (cand_idx < is_top_idx);
    end
`endif

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        ack_take = 1'b0;
        ret_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    state_d = REQ;
                    latch   = 1'b1;
                end
            end
            REQ: begin
`ifdef INT_CTRL_NESTING_EN
                ret_take = int_ret && is_any;
`endif
                if (withdraw) begin
                    state_d = is_any ? SERVICE : IDLE;
                end else if (int_ack) begin
                    state_d  = SERVICE;
                    ack_take = 1'b1;
                end
            end
            SERVICE: begin
                if (int_ret && is_any) begin
                    ret_take = 1'b1;
                    if ((in_service_q & ~is_top_oh) == '0) state_d = IDLE;
`ifdef INT_CTRL_NESTING_EN
                end else if (preempt) begin
                    state_d = REQ;
                    latch   = 1'b1;
`endif
                end else if (!is_any) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs (request drops at once when the latched channel is withdrawn)
    always_comb begin
        int_req = (state_q == REQ) && !withdraw;
        int_vec = int_vec_q;
    end

    // The first cycle after reset only primes the edge history, so a line already high is not an edge.
    always_comb begin
        irq_prev_d   = irq_in;
        armed_d      = 1'b1;
        edge_set     = armed_q ? (irq_in & ~irq_prev_q) : '0;
        pending_d    = (pending_q & ~(ack_take ? req_oh : '0)) | edge_set;
        in_service_d = in_service_q;
        if (ret_take) in_service_d = in_service_d & ~is_top_oh;
        if (ack_take) in_service_d = in_service_d | req_oh;
        mask_d       = mask_w_en ? mask_w_data : mask_q;
        gie_d        = gie_w_en ? gie_w_data : gie_q;
        req_ch_d     = latch ? cand_idx : req_ch_q;
        int_vec_d    = latch ? cand_vec : int_vec_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_prev_q   <= '0;
            armed_q      <= 1'b0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= '0;
            gie_q        <= 1'b0;
            req_ch_q     <= '0;
            int_vec_q    <= VEC_RST;
        end else begin
            irq_prev_q   <= irq_prev_d;
            armed_q      <= armed_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            gie_q        <= gie_d;
            req_ch_q     <= req_ch_d;
            int_vec_q    <= int_vec_d;
        end
    end

    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;
    assign gie        = gie_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl; expected vectors are queued when an edge is driven.
module tb_int_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_w_en;
    logic [3:0] mask_w_data;
    logic       gie_w_en;
    logic       gie_w_data;
    logic       int_ack;
    logic       int_ret;
    logic       int_req;
    logic [7:0] int_vec;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [3:0] mask;
    logic       gie;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    bit seen;

    int_ctrl dut (
        .clock(clock), .reset(reset), .irq_in(irq_in),
        .mask_w_en(mask_w_en), .mask_w_data(mask_w_data),
        .gie_w_en(gie_w_en), .gie_w_data(gie_w_data),
        .int_ack(int_ack), .int_ret(int_ret),
        .int_req(int_req), .int_vec(int_vec), .pending(pending),
        .in_service(in_service), .mask(mask), .gie(gie)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_w_en = 1'b1; mask_w_data = v; tick(); mask_w_en = 1'b0;
    endtask

    task automatic write_gie(input logic v);
        gie_w_en = 1'b1; gie_w_data = v; tick(); gie_w_en = 1'b0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic do_ret();
        int_ret = 1'b1; tick(); int_ret = 1'b0;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        irq_in = v; tick(); irq_in = 4'b0;
    endtask

    task automatic wait_req(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            if (int_req === 1'b1) found = 1'b1;
            else tick();
        end
        if (!found && int_req === 1'b1) found = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        checks++;
        if ({pending, in_service, mask, gie, int_req} !== 15'b0 || int_vec !== 8'hE0) begin
            failures++;
            $display("FAIL reset_values: pend=%b insvc=%b mask=%b gie=%b req=%b vec=%h required all 0, vec=e0",
                     pending, in_service, mask, gie, int_req, int_vec);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        write_mask(4'b1111);
        write_gie(1'b1);
        exp_q.push_back(8'hE8);
        pulse_irq(4'b0100);
        checks++;
        if (pending !== 4'b0100 || int_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_pending: pend=%b req=%b required 0100/0", pending, int_req);
        end
        tick();
        checks++;
        if (int_req !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency: req=%b required 1", int_req);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (int_vec !== exp_v) begin
            failures++;
            $display("FAIL basic_vec: got %h required %h", int_vec, exp_v);
        end
        do_ack();
        checks++;
        if (in_service !== 4'b0100 || pending !== 4'b0000 || int_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_ack: insvc=%b pend=%b req=%b required 0100/0000/0", in_service, pending, int_req);
        end
        do_ret();
        checks++;
        if (in_service !== 4'b0000 || int_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_ret: insvc=%b req=%b required 0000/0", in_service, int_req);
        end
    endtask

    task automatic test_priority();
        exp_q.push_back(8'hE4);
        exp_q.push_back(8'hEC);
        pulse_irq(4'b1010);
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL prio_first: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        do_ack();
        checks++;
        if (in_service !== 4'b0010 || pending !== 4'b1000) begin
            failures++;
            $display("FAIL prio_ack: insvc=%b pend=%b required 0010/1000", in_service, pending);
        end
        do_ret();
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL prio_second: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        do_ack();
        do_ret();
    endtask

    task automatic test_mask();
        int req_hits;
        write_mask(4'b1110);
        pulse_irq(4'b0001);
        req_hits = 0;
        for (int i = 0; i < 3; i++) begin
            if (int_req !== 1'b0) req_hits++;
            tick();
        end
        checks++;
        if (pending[0] !== 1'b1 || req_hits != 0) begin
            failures++;
            $display("FAIL mask_blocks: pend0=%b req_cycles=%0d required 1/0", pending[0], req_hits);
        end
        exp_q.push_back(8'hE0);
        write_mask(4'b1111);
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("FAIL mask_early: req=%b required 0 one cycle after strobe", int_req);
        end
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (int_req !== 1'b1 || int_vec !== exp_v) begin
            failures++;
            $display("FAIL mask_release: req=%b vec=%h required 1/%h", int_req, int_vec, exp_v);
        end
        do_ack();
        do_ret();
    endtask

    task automatic test_gie_withdraw();
        exp_q.push_back(8'hE8);
        pulse_irq(4'b0100);
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (int_req !== 1'b1 || int_vec !== exp_v) begin
            failures++;
            $display("FAIL gie_req: req=%b vec=%h required 1/%h", int_req, int_vec, exp_v);
        end
        write_gie(1'b0);
        checks++;
        if (int_req !== 1'b0 || pending !== 4'b0100) begin
            failures++;
            $display("FAIL gie_drop: req=%b pend=%b required 0/0100", int_req, pending);
        end
        tick(2);
        checks++;
        if (int_req !== 1'b0 || in_service !== 4'b0000) begin
            failures++;
            $display("FAIL gie_stays_low: req=%b insvc=%b required 0/0000", int_req, in_service);
        end
        exp_q.push_back(8'hE8);
        write_gie(1'b1);
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL gie_reissue: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        do_ack();
        do_ret();
    endtask

    task automatic test_ack_edge();
        exp_q.push_back(8'hE4);
        pulse_irq(4'b0010);
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL ackedge_req: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        irq_in = 4'b0010;
        int_ack = 1'b1;
        tick();
        irq_in = 4'b0;
        int_ack = 1'b0;
        checks++;
        if (in_service !== 4'b0010 || pending !== 4'b0010 || int_req !== 1'b0) begin
            failures++;
            $display("FAIL ackedge_keep: insvc=%b pend=%b req=%b required 0010/0010/0", in_service, pending, int_req);
        end
        exp_q.push_back(8'hE4);
        do_ret();
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL ackedge_again: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        do_ack();
        do_ret();
        int_ack = 1'b1;
        int_ret = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b0;
        checks++;
        if (in_service !== 4'b0000 || pending !== 4'b0000 || int_req !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack_ret: insvc=%b pend=%b req=%b required 0000/0000/0", in_service, pending, int_req);
        end
    endtask

    task automatic test_preempt();
        exp_q.push_back(8'hEC);
        pulse_irq(4'b1000);
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL preempt_ch3: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        do_ack();
        checks++;
        if (in_service !== 4'b1000) begin
            failures++;
            $display("FAIL preempt_svc3: insvc=%b required 1000", in_service);
        end
        exp_q.push_back(8'hE0);
        pulse_irq(4'b0001);
`ifdef INT_CTRL_NESTING_EN
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL nest_req: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        do_ack();
        checks++;
        if (in_service !== 4'b1001) begin
            failures++;
            $display("FAIL nest_ack: insvc=%b required 1001", in_service);
        end
        do_ret();
        checks++;
        if (in_service !== 4'b1000 || int_req !== 1'b0) begin
            failures++;
            $display("FAIL nest_ret1: insvc=%b req=%b required 1000/0", in_service, int_req);
        end
        do_ret();
        checks++;
        if (in_service !== 4'b0000) begin
            failures++;
            $display("FAIL nest_ret2: insvc=%b required 0000", in_service);
        end
`else
        begin
            int req_hits = 0;
            for (int i = 0; i < 4; i++) begin
                if (int_req !== 1'b0) req_hits++;
                tick();
            end
            checks++;
            if (req_hits != 0 || in_service !== 4'b1000) begin
                failures++;
                $display("FAIL nopreempt_hold: req_cycles=%0d insvc=%b required 0/1000", req_hits, in_service);
            end
        end
        do_ret();
        checks++;
        if (in_service !== 4'b0000) begin
            failures++;
            $display("FAIL nopreempt_ret: insvc=%b required 0000", in_service);
        end
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL nopreempt_after: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        do_ack();
        do_ret();
`endif
    endtask

    task automatic test_reset_mid_service();
        exp_q.push_back(8'hE8);
        pulse_irq(4'b0100);
        wait_req(8, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || int_vec !== exp_v) begin
            failures++;
            $display("FAIL rst_setup: req_seen=%0d vec=%h required 1/%h", seen, int_vec, exp_v);
        end
        do_ack();
        irq_in = 4'b1011;
        tick();
        checks++;
        if (pending !== 4'b1011 || in_service !== 4'b0100) begin
            failures++;
            $display("FAIL rst_pre: pend=%b insvc=%b required 1011/0100", pending, in_service);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({pending, in_service, mask, gie, int_req} !== 15'b0 || int_vec !== 8'hE0) begin
            failures++;
            $display("FAIL rst_mid: pend=%b insvc=%b mask=%b gie=%b req=%b vec=%h required all 0, vec=e0",
                     pending, in_service, mask, gie, int_req, int_vec);
        end
        reset = 1'b0;
        tick(3);
        checks++;
        if (pending !== 4'b0000 || int_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_held_level: pend=%b req=%b required 0000/0", pending, int_req);
        end
        irq_in = 4'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        irq_in = 4'b0;
        mask_w_en = 1'b0;
        mask_w_data = 4'b0;
        gie_w_en = 1'b0;
        gie_w_data = 1'b0;
        int_ack = 1'b0;
        int_ret = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_gie_withdraw();
        test_ack_edge();
        test_preempt();
        test_reset_mid_service();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
